bellek_erisim_birimi: RTL and testbench

Load/store unit of the memory stage, directly downstream of the execute-stage ALU. It takes the ALU sum as the effective address and rs2 as store data. It runs a single-outstanding request/ready handshake with the data memory and produces byte-lane masks and replicated store data. Load results are extracted and sign- or zero-extended, and the upstream pipeline is stalled while an access is in flight.

---
 rtl/bellek_erisim_birimi_if.sv | 51 +++++
 rtl/bellek_erisim_birimi.sv | 171 +++++++++++++++++
 tb/tb_bellek_erisim_birimi.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bellek_erisim_birimi_if.sv
// ---------------------------------------------------------------------------
// bellek_erisim_birimi_if
// Purpose : groups the pipeline-side request signals and the data-memory
//           bus of the load/store unit into one bundle.
// Signals :
//   pipeline -> unit : gecerli_i, oku_i, yaz_i, islem_i, adres_i, veri_i
//   unit -> memory   : bellek_istek_o, bellek_yaz_o, bellek_adres_o,
//                      bellek_veri_o, bellek_maske_o
//   memory -> unit   : bellek_hazir_i, bellek_veri_i
//   unit -> pipeline : sonuc_o, sonuc_gecerli_o, durdur_o, hizasiz_o
//
// Handshake: bellek_istek_o is the valid, bellek_hazir_i the ready. Once
// bellek_istek_o rises, it and every bellek_* output stay constant until a
// cycle with bellek_hazir_i = 1; that cycle is the transfer (read data is
// sampled in it). Only one request is ever outstanding, and bellek_hazir_i
// is ignored while no request is pending.
// Modports: slave = the load/store unit, master = its environment.
// ---------------------------------------------------------------------------
interface bellek_erisim_birimi_if;
  logic        gecerli_i;
  logic        oku_i;
  logic        yaz_i;
  logic [2:0]  islem_i;
  logic [31:0] adres_i;
  logic [31:0] veri_i;
  logic        bellek_istek_o;
  logic        bellek_yaz_o;
  logic [31:0] bellek_adres_o;
  logic [31:0] bellek_veri_o;
  logic [3:0]  bellek_maske_o;
  logic        bellek_hazir_i;
  logic [31:0] bellek_veri_i;
  logic [31:0] sonuc_o;
  logic        sonuc_gecerli_o;
  logic        durdur_o;
  logic        hizasiz_o;

  modport slave (
    input  gecerli_i, oku_i, yaz_i, islem_i, adres_i, veri_i,
    input  bellek_hazir_i, bellek_veri_i,
    output bellek_istek_o, bellek_yaz_o, bellek_adres_o, bellek_veri_o,
    output bellek_maske_o, sonuc_o, sonuc_gecerli_o, durdur_o, hizasiz_o
  );

  modport master (
    output gecerli_i, oku_i, yaz_i, islem_i, adres_i, veri_i,
    output bellek_hazir_i, bellek_veri_i,
    input  bellek_istek_o, bellek_yaz_o, bellek_adres_o, bellek_veri_o,
    input  bellek_maske_o, sonuc_o, sonuc_gecerli_o, durdur_o, hizasiz_o
  );
endinterface

// File: rtl/bellek_erisim_birimi.sv
// ---------------------------------------------------------------------------
// bellek_erisim_birimi
// Purpose : memory-stage load/store unit. Takes the ALU sum as effective
//           address and rs2 as store data, runs a single-outstanding
//           request/ready access to data memory, builds byte-lane masks and
//           lane-replicated store data, extracts and extends load results,
//           and stalls upstream while an access is in flight.
// Ports   :
//   clk_i   - clock, all state updates on the rising edge
//   rst_i   - synchronous active-high reset
//   bus     - bellek_erisim_birimi_if.slave (pipeline + memory signals)
//   durum_o - current FSM state (0 = BOSTA, 1 = BEKLE), for observation
// ---------------------------------------------------------------------------
module bellek_erisim_birimi (
  input  logic                          clk_i,
  input  logic                          rst_i,
  bellek_erisim_birimi_if.slave         bus,
  output logic                          durum_o
);

  typedef enum logic {BOSTA = 1'b0, BEKLE = 1'b1} durum_t;

  durum_t      durum_q, durum_d;
  logic        istek_q, istek_d;
  logic        yaz_q, yaz_d;
  logic [31:0] adres_q, adres_d;
  logic [31:0] veri_q, veri_d;
  logic [3:0]  maske_q, maske_d;
  logic [2:0]  islem_q, islem_d;
  logic [1:0]  ofs_q, ofs_d;
  logic [31:0] sonuc_q, sonuc_d;
  logic        sonuc_gecerli_q, sonuc_gecerli_d;
  logic        hizasiz_q, hizasiz_d;

  // Decode of the incoming request (only meaningful in BOSTA).
  logic        bellek_islemi;
  logic        hizali;
  logic        baslat;
  logic [3:0]  maske_yeni;
  logic [31:0] veri_yeni;

  // Load extraction from the returned word.
  logic [7:0]  bayt;
  logic [15:0] yarim;
  logic [31:0] yuklenen;

  // funct3[1:0]: 00 byte, 01 half, anything else word. This maps the
  // unlisted codes (011, 110, 111) onto word size without a separate case.
  always_comb begin
    bellek_islemi = bus.gecerli_i & (bus.oku_i | bus.yaz_i);
    maske_yeni    = 4'b1111;
    veri_yeni     = bus.veri_i;
    hizali        = (bus.adres_i[1:0] == 2'b00);
    case (bus.islem_i[1:0])
      2'b00: begin
        hizali     = 1'b1;
        maske_yeni = 4'b0001 << bus.adres_i[1:0];
        veri_yeni  = {4{bus.veri_i[7:0]}};
      end
      2'b01: begin
        hizali     = ~bus.adres_i[0];
        maske_yeni = bus.adres_i[1] ? 4'b1100 : 4'b0011;
        veri_yeni  = {2{bus.veri_i[15:0]}};
      end
      default: ;
    endcase
    baslat = bellek_islemi & hizali;
  end

  always_comb begin
    case (ofs_q)
      2'd0:    bayt = bus.bellek_veri_i[7:0];
      2'd1:    bayt = bus.bellek_veri_i[15:8];
      2'd2:    bayt = bus.bellek_veri_i[23:16];
      default: bayt = bus.bellek_veri_i[31:24];
    endcase
    yarim = ofs_q[1] ? bus.bellek_veri_i[31:16] : bus.bellek_veri_i[15:0];
    // funct3[2] selects zero-extension (BU/HU).
    case (islem_q[1:0])
      2'b00:   yuklenen = {{24{bayt[7] & ~islem_q[2]}}, bayt};
      2'b01:   yuklenen = {{16{yarim[15] & ~islem_q[2]}}, yarim};
      default: yuklenen = bus.bellek_veri_i;
    endcase
  end

  // Next-state and register updates.
  always_comb begin
    durum_d         = durum_q;
    istek_d         = istek_q;
    yaz_d           = yaz_q;
    adres_d         = adres_q;
    veri_d          = veri_q;
    maske_d         = maske_q;
    islem_d         = islem_q;
    ofs_d           = ofs_q;
    sonuc_d         = sonuc_q;
    sonuc_gecerli_d = 1'b0;
    hizasiz_d       = 1'b0;
    case (durum_q)
      BOSTA: begin
        if (baslat) begin
          durum_d = BEKLE;
          istek_d = 1'b1;
          yaz_d   = bus.yaz_i;   // store wins when both oku_i and yaz_i are set
          adres_d = {bus.adres_i[31:2], 2'b00};
          veri_d  = veri_yeni;
          maske_d = maske_yeni;
          islem_d = bus.islem_i;
          ofs_d   = bus.adres_i[1:0];
        end else if (bellek_islemi) begin
          hizasiz_d = 1'b1;
        end
      end
      BEKLE: begin
        if (bus.bellek_hazir_i) begin
          durum_d         = BOSTA;
          istek_d         = 1'b0;
          sonuc_gecerli_d = 1'b1;
          if (!yaz_q) begin
            sonuc_d = yuklenen;
          end
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q         <= BOSTA;
      istek_q         <= 1'b0;
      yaz_q           <= 1'b0;
      adres_q         <= '0;
      veri_q          <= '0;
      maske_q         <= '0;
      islem_q         <= '0;
      ofs_q           <= '0;
      sonuc_q         <= '0;
      sonuc_gecerli_q <= 1'b0;
      hizasiz_q       <= 1'b0;
    end else begin
      durum_q         <= durum_d;
      istek_q         <= istek_d;
      yaz_q           <= yaz_d;
      adres_q         <= adres_d;
      veri_q          <= veri_d;
      maske_q         <= maske_d;
      islem_q         <= islem_d;
      ofs_q           <= ofs_d;
      sonuc_q         <= sonuc_d;
      sonuc_gecerli_q <= sonuc_gecerli_d;
      hizasiz_q       <= hizasiz_d;
    end
  end

  // Stall is combinational and drops in the completion cycle so upstream
  // advances on the same edge the access retires.
  assign bus.durdur_o = ((durum_q == BOSTA) & baslat) |
                        ((durum_q == BEKLE) & ~bus.bellek_hazir_i);

  assign bus.bellek_istek_o  = istek_q;
  assign bus.bellek_yaz_o    = yaz_q;
  assign bus.bellek_adres_o  = adres_q;
  assign bus.bellek_veri_o   = veri_q;
  assign bus.bellek_maske_o  = maske_q;
  assign bus.sonuc_o         = sonuc_q;
  assign bus.sonuc_gecerli_o = sonuc_gecerli_q;
  assign bus.hizasiz_o       = hizasiz_q;
  assign durum_o             = durum_q;

endmodule

// File: tb/tb_bellek_erisim_birimi.sv
module tb_bellek_erisim_birimi;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic durum_o;

  bellek_erisim_birimi_if bus ();

  bellek_erisim_birimi dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus.slave),
    .durum_o (durum_o)
  );

  // Clock / reset block
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        oku;
    logic        yaz;
    logic [2:0]  islem;
    logic [31:0] adres;
    logic [31:0] veri;
    logic [31:0] rdata;
    logic        hiz;
    logic [31:0] e_adres;
    logic [31:0] e_veri;
    logic [3:0]  e_maske;
    logic        e_yaz;
    logic [31:0] e_sonuc;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic oku, input logic yaz, input logic [2:0] islem,
                              input logic [31:0] adres, input logic [31:0] veri,
                              input logic [31:0] rdata, input logic hiz,
                              input logic [31:0] e_adres, input logic [31:0] e_veri,
                              input logic [3:0] e_maske, input logic e_yaz,
                              input logic [31:0] e_sonuc);
    vec_t v;
    v.oku = oku; v.yaz = yaz; v.islem = islem; v.adres = adres; v.veri = veri;
    v.rdata = rdata; v.hiz = hiz; v.e_adres = e_adres; v.e_veri = e_veri;
    v.e_maske = e_maske; v.e_yaz = e_yaz; v.e_sonuc = e_sonuc;
    return v;
  endfunction

  // Scoreboard check
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.gecerli_i      = 1'b0;
    bus.oku_i          = 1'b0;
    bus.yaz_i          = 1'b0;
    bus.islem_i        = 3'b000;
    bus.adres_i        = '0;
    bus.veri_i         = '0;
    bus.bellek_hazir_i = 1'b0;
    bus.bellek_veri_i  = '0;
  endtask

  task automatic drive_req(input logic oku, input logic yaz, input logic [2:0] islem,
                           input logic [31:0] adres, input logic [31:0] veri);
    bus.gecerli_i = 1'b1;
    bus.oku_i     = oku;
    bus.yaz_i     = yaz;
    bus.islem_i   = islem;
    bus.adres_i   = adres;
    bus.veri_i    = veri;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_istek"},   {31'b0, bus.bellek_istek_o}, 32'h0);
    chk({tag, "_yaz"},     {31'b0, bus.bellek_yaz_o}, 32'h0);
    chk({tag, "_adres"},   bus.bellek_adres_o, 32'h0);
    chk({tag, "_veri"},    bus.bellek_veri_o, 32'h0);
    chk({tag, "_maske"},   {28'b0, bus.bellek_maske_o}, 32'h0);
    chk({tag, "_sonuc"},   bus.sonuc_o, 32'h0);
    chk({tag, "_sgec"},    {31'b0, bus.sonuc_gecerli_o}, 32'h0);
    chk({tag, "_hizasiz"}, {31'b0, bus.hizasiz_o}, 32'h0);
    chk({tag, "_durum"},   {31'b0, durum_o}, 32'h0);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    drive_req(v.oku, v.yaz, v.islem, v.adres, v.veri);
    #1;
    chk({t, "_durdur_issue"}, {31'b0, bus.durdur_o}, {31'b0, ~v.hiz});
    tick();
    idle_inputs();
    #1;
    if (v.hiz) begin
      chk({t, "_hizasiz"}, {31'b0, bus.hizasiz_o}, 32'h1);
      chk({t, "_istek_hiz"}, {31'b0, bus.bellek_istek_o}, 32'h0);
      chk({t, "_durdur_hiz"}, {31'b0, bus.durdur_o}, 32'h0);
      chk({t, "_sgec_hiz"}, {31'b0, bus.sonuc_gecerli_o}, 32'h0);
      tick();
      chk({t, "_hizasiz_pulse"}, {31'b0, bus.hizasiz_o}, 32'h0);
    end else begin
      chk({t, "_istek"}, {31'b0, bus.bellek_istek_o}, 32'h1);
      chk({t, "_adres"}, bus.bellek_adres_o, v.e_adres);
      chk({t, "_veri"},  bus.bellek_veri_o, v.e_veri);
      chk({t, "_maske"}, {28'b0, bus.bellek_maske_o}, {28'b0, v.e_maske});
      chk({t, "_yaz"},   {31'b0, bus.bellek_yaz_o}, {31'b0, v.e_yaz});
      chk({t, "_durdur_wait"}, {31'b0, bus.durdur_o}, 32'h1);
      bus.bellek_hazir_i = 1'b1;
      bus.bellek_veri_i  = v.rdata;
      #1;
      chk({t, "_durdur_done"}, {31'b0, bus.durdur_o}, 32'h0);
      tick();
      idle_inputs();
      #1;
      chk({t, "_sgec"},  {31'b0, bus.sonuc_gecerli_o}, 32'h1);
      chk({t, "_hiz0"},  {31'b0, bus.hizasiz_o}, 32'h0);
      chk({t, "_istek_off"}, {31'b0, bus.bellek_istek_o}, 32'h0);
      chk({t, "_sonuc"}, bus.sonuc_o, v.e_sonuc);
      tick();
      chk({t, "_sgec_pulse"}, {31'b0, bus.sonuc_gecerli_o}, 32'h0);
    end
  endtask

  initial begin
    // Stimulus table: oku yaz islem adres veri rdata hiz | adres veri maske yaz sonuc
    vecs[0]  = mk(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 32'h0, 4'b1111, 0, 32'hDEADBEEF);
    vecs[1]  = mk(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 32'h100, 32'h0, 4'b1000, 0, 32'hFFFFFF80);
    vecs[2]  = mk(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 32'h100, 32'h0, 4'b1000, 0, 32'h00000080);
    vecs[3]  = mk(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0, 32'h100, 32'h0, 4'b1100, 0, 32'hFFFF80FF);
    vecs[4]  = mk(0, 1, 3'b000, 32'h202, 32'h12345678, 32'h0, 0, 32'h200, 32'h78787878, 4'b0100, 1, 32'hFFFF80FF);
    vecs[5]  = mk(0, 1, 3'b001, 32'h301, 32'h12345678, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 0, 32'h0);
    vecs[6]  = mk(1, 0, 3'b101, 32'h100, 32'h0, 32'h80FF1234, 0, 32'h100, 32'h0, 4'b0011, 0, 32'h00001234);
    vecs[7]  = mk(0, 1, 3'b010, 32'h104, 32'hCAFEBABE, 32'h0, 0, 32'h104, 32'hCAFEBABE, 4'b1111, 1, 32'h00001234);
    vecs[8]  = mk(1, 0, 3'b010, 32'h106, 32'h0, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 0, 32'h0);
    vecs[9]  = mk(1, 0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 32'h100, 32'h0, 4'b0010, 0, 32'h0000007F);
    vecs[10] = mk(0, 1, 3'b001, 32'h002, 32'h0000ABCD, 32'h0, 0, 32'h000, 32'hABCDABCD, 4'b1100, 1, 32'h0000007F);
    vecs[11] = mk(1, 1, 3'b000, 32'h001, 32'h00000055, 32'hFFFFFFFF, 0, 32'h000, 32'h55555555, 4'b0010, 1, 32'h0000007F);
    vecs[12] = mk(1, 0, 3'b011, 32'h008, 32'h0, 32'h87654321, 0, 32'h008, 32'h0, 4'b1111, 0, 32'h87654321);
    vecs[13] = mk(1, 0, 3'b111, 32'h00A, 32'h0, 32'h0, 1, 32'h0, 32'h0, 4'b0000, 0, 32'h0);
    vecs[14] = mk(1, 0, 3'b001, 32'h100, 32'h0, 32'h00008001, 0, 32'h100, 32'h0, 4'b0011, 0, 32'hFFFF8001);
    vecs[15] = mk(1, 0, 3'b101, 32'h102, 32'h0, 32'h7FFF0000, 0, 32'h100, 32'h0, 4'b1100, 0, 32'h00007FFF);

    idle_inputs();
    rst_i = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    rst_i = 1'b0;
    tick();
    check_all_zero("after_reset");

    // Non-memory instruction and invalid slot: no stall, no request.
    drive_req(1'b0, 1'b0, 3'b010, 32'h100, 32'h1);
    #1;
    chk("nonmem_durdur", {31'b0, bus.durdur_o}, 32'h0);
    tick();
    bus.gecerli_i = 1'b0;
    bus.oku_i     = 1'b1;
    #1;
    chk("nonmem_istek", {31'b0, bus.bellek_istek_o}, 32'h0);
    chk("invalid_durdur", {31'b0, bus.durdur_o}, 32'h0);
    tick();
    chk("invalid_istek", {31'b0, bus.bellek_istek_o}, 32'h0);
    chk("invalid_hizasiz", {31'b0, bus.hizasiz_o}, 32'h0);
    idle_inputs();

    // Ready while idle is ignored.
    bus.bellek_hazir_i = 1'b1;
    tick();
    bus.bellek_hazir_i = 1'b0;
    #1;
    chk("idle_hazir_sgec", {31'b0, bus.sonuc_gecerli_o}, 32'h0);
    chk("idle_hazir_durum", {31'b0, durum_o}, 32'h0);

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      run_vec(i, vecs[i]);
    end

    // LW with ready delayed 5 request cycles, then SW right behind it.
    drive_req(1'b1, 1'b0, 3'b010, 32'h440, 32'h0);
    #1;
    chk("slow_durdur_N", {31'b0, bus.durdur_o}, 32'h1);
    tick();
    idle_inputs();
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("slow_istek_%0d", c), {31'b0, bus.bellek_istek_o}, 32'h1);
      chk($sformatf("slow_adres_%0d", c), bus.bellek_adres_o, 32'h440);
      chk($sformatf("slow_maske_%0d", c), {28'b0, bus.bellek_maske_o}, 32'hF);
      chk($sformatf("slow_durdur_%0d", c), {31'b0, bus.durdur_o}, 32'h1);
      chk($sformatf("slow_durum_%0d", c), {31'b0, durum_o}, 32'h1);
      tick();
    end
    bus.bellek_hazir_i = 1'b1;
    bus.bellek_veri_i  = 32'h0BADF00D;
    #1;
    chk("slow_istek_5", {31'b0, bus.bellek_istek_o}, 32'h1);
    chk("slow_adres_5", bus.bellek_adres_o, 32'h440);
    chk("slow_durdur_5", {31'b0, bus.durdur_o}, 32'h0);
    tick();
    idle_inputs();
    drive_req(1'b0, 1'b1, 3'b010, 32'h480, 32'h11223344);
    #1;
    chk("slow_sgec", {31'b0, bus.sonuc_gecerli_o}, 32'h1);
    chk("slow_sonuc", bus.sonuc_o, 32'h0BADF00D);
    chk("slow_istek_gap", {31'b0, bus.bellek_istek_o}, 32'h0);
    chk("sw_durdur", {31'b0, bus.durdur_o}, 32'h1);
    tick();
    idle_inputs();
    #1;
    chk("sw_istek", {31'b0, bus.bellek_istek_o}, 32'h1);
    chk("sw_yaz", {31'b0, bus.bellek_yaz_o}, 32'h1);
    chk("sw_adres", bus.bellek_adres_o, 32'h480);
    chk("sw_veri", bus.bellek_veri_o, 32'h11223344);
    chk("slow_sgec_pulse", {31'b0, bus.sonuc_gecerli_o}, 32'h0);
    bus.bellek_hazir_i = 1'b1;
    tick();
    bus.bellek_hazir_i = 1'b0;
    #1;
    chk("sw_sgec", {31'b0, bus.sonuc_gecerli_o}, 32'h1);
    chk("sw_sonuc_kept", bus.sonuc_o, 32'h0BADF00D);
    tick();

    // Reset in the 3rd BEKLE cycle, ready the cycle after.
    drive_req(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    tick();
    idle_inputs();
    tick();
    tick();
    rst_i = 1'b1;
    #1;
    chk("rst_mid_durum", {31'b0, durum_o}, 32'h1);
    tick();
    rst_i = 1'b0;
    bus.bellek_hazir_i = 1'b1;
    bus.bellek_veri_i  = 32'hFFFFFFFF;
    #1;
    check_all_zero("rst_mid");
    chk("rst_mid_durdur", {31'b0, bus.durdur_o}, 32'h0);
    tick();
    bus.bellek_hazir_i = 1'b0;
    #1;
    check_all_zero("rst_after_hazir");
    tick();
    chk("rst_late_sgec", {31'b0, bus.sonuc_gecerli_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // hizasiz_o and sonuc_gecerli_o must never be high together.
  always @(negedge clk_i) begin
    if (!rst_i && bus.hizasiz_o && bus.sonuc_gecerli_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL pulse_overlap: hizasiz=1 sonuc_gecerli=1 expected not both at %0t", $time);
    end
  end

endmodule
